// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the round-robin decoder arbiter.
//   IDX_W / N_REQ : index width and requester count. The decoder is 3-to-8,
//                   so these are fixed together.
//   idx_t / vec_t : requester index and request/grant vector types.
//   state_t       : arbiter FSM states.
//   pick_t        : result of a rotating priority search. The index field is
//                   only meaningful when found=1.
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int IDX_W = 3;
    localparam int N_REQ = 8;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [N_REQ-1:0] vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic found;
        idx_t idx;
    } pick_t;

endpackage

// File: rtl/dec3to8_en.sv
// -----------------------------------------------------------------------------
// dec3to8_en
// Combinational 3-to-8 decoder with an enable input.
//   a  : in  [2:0] select index
//   en : in        enable; when low the output is all zeros
//   y  : out [7:0] one-hot select of a when en=1, otherwise 8'h00
// -----------------------------------------------------------------------------
module dec3to8_en
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] a,
    input  logic             en,
    output logic [N_REQ-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_dec_arbiter.sv
// -----------------------------------------------------------------------------
// rr_dec_arbiter
// Round-robin arbiter for 8 requesters sharing one 3-to-8 decoder output bus.
// A winner holds the grant for at most MAX_HOLD consecutive cycles while it
// keeps requesting. When its lease runs out, the search starts at the next
// index, so any other requester gets priority and the holder is checked last.
// If the holder drops its request, the grant passes to the next requester on
// the same edge, so no idle cycle is inserted.
//
// Ports
//   clk       : in        system clock; all state changes on the rising edge
//   rst       : in        synchronous active-high reset
//   req       : in  [7:0] level-sensitive request vector
//   gnt_valid : out       a grant is active
//   gnt_idx   : out [2:0] winner index; holds its last value while idle
//   gnt       : out [7:0] one-hot grant = decode(gnt_idx) gated by gnt_valid
//   hold_cnt  : out [3:0] cycles the current winner has held the grant, 0-based
//
// Parameters
//   MAX_HOLD  : lease length in cycles, legal range 1..15
//
// Every output comes straight from a flop. The decoder is driven from the
// next-state index and valid, so gnt_q is aligned with gnt_idx_q.
// -----------------------------------------------------------------------------
module rr_dec_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] gnt,
    output logic [3:0]       hold_cnt
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    // Rotating priority search. The loop runs from the farthest offset down
    // to offset 0, so the last match it records is the one nearest start.
    function automatic pick_t pick(input vec_t r, input idx_t start);
        pick_t p;
        idx_t  i;
        p.found = 1'b0;
        p.idx   = start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            i = start + idx_t'(k);
            if (r[i]) begin
                p.found = 1'b1;
                p.idx   = i;
            end
        end
        return p;
    endfunction

    state_t     state_q, state_d;
    idx_t       idx_q,   idx_d;
    idx_t       ptr_q,   ptr_d;
    logic [3:0] hold_q,  hold_d;
    logic       valid_q, valid_d;
    vec_t       gnt_q,   gnt_d;

    pick_t      pick_ptr;
    pick_t      pick_next;
    idx_t       idx_inc;

    assign idx_inc   = idx_q + idx_t'(1);
    assign pick_ptr  = pick(req, ptr_q);
    assign pick_next = pick(req, idx_inc);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                if (pick_ptr.found) begin
                    state_d = GRANT;
                    idx_d   = pick_ptr.idx;
                    hold_d  = '0;
                    valid_d = 1'b1;
                end
            end

            GRANT: begin
                if (!req[idx_q]) begin
                    // The holder released its request. Hand off directly to
                    // the next requester, or go idle if nobody is requesting.
                    ptr_d  = idx_inc;
                    hold_d = '0;
                    if (pick_next.found) begin
                        idx_d = pick_next.idx;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end else if (hold_q >= HOLD_LAST) begin
                    // The lease has expired. req[idx_q] is set, so the search
                    // always finds a winner. If no one else is requesting, the
                    // holder itself is found and re-granted with a new lease.
                    ptr_d  = idx_inc;
                    idx_d  = pick_next.idx;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    dec3to8_en u_dec (
        .a  (idx_d),
        .en (valid_d),
        .y  (gnt_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt_valid = valid_q;
    assign gnt_idx   = idx_q;
    assign gnt       = gnt_q;
    assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
module tb_rr_dec_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic [3:0] hold_cnt;

    int checks = 0;
    int errors = 0;

    // Packed expectation: {valid, idx, gnt, hold}
    logic [15:0] sb[$];

    typedef struct packed {
        logic [7:0]  rq;
        logic        rs;
        logic [15:0] ex;
    } step_t;

    rr_dec_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt       (gnt),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Build one step: the inputs applied before an edge and the outputs
    // required just after that edge.
    function automatic step_t s(input logic [7:0] rq, input logic rs,
                                input logic v, input logic [2:0] i,
                                input logic [3:0] h);
        step_t t;
        logic [7:0] g;
        g = 8'h00;
        if (v) g = 8'h01 << i;
        t.rq = rq;
        t.rs = rs;
        t.ex = {v, i, g, h};
        return t;
    endfunction

    task automatic test_reset();
        step_t st[$];
        logic [15:0] e, o;
        st.push_back(s(8'hFF, 1, 0, 0, 0));
        st.push_back(s(8'hFF, 1, 0, 0, 0));
        st.push_back(s(8'hFF, 0, 1, 0, 0));
        foreach (st[k]) begin
            req = st[k].rq; rst = st[k].rs; sb.push_back(st[k].ex);
            @(posedge clk); #1;
            e = sb.pop_front(); o = {gnt_valid, gnt_idx, gnt, hold_cnt};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset step %0d: observed %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_single();
        step_t st[$];
        logic [15:0] e, o;
        st.push_back(s(8'h00, 1, 0, 0, 0));
        for (int c = 0; c < 10; c++) st.push_back(s(8'h20, 0, 1, 3'd5, 4'(c % 4)));
        foreach (st[k]) begin
            req = st[k].rq; rst = st[k].rs; sb.push_back(st[k].ex);
            @(posedge clk); #1;
            e = sb.pop_front(); o = {gnt_valid, gnt_idx, gnt, hold_cnt};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single step %0d: observed %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_fairness();
        step_t st[$];
        logic [15:0] e, o;
        st.push_back(s(8'h00, 1, 0, 0, 0));
        for (int c = 0; c < 12; c++)
            st.push_back(s(8'h81, 0, 1, ((c / 4) % 2 == 1) ? 3'd7 : 3'd0, 4'(c % 4)));
        foreach (st[k]) begin
            req = st[k].rq; rst = st[k].rs; sb.push_back(st[k].ex);
            @(posedge clk); #1;
            e = sb.pop_front(); o = {gnt_valid, gnt_idx, gnt, hold_cnt};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL fairness step %0d: observed %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_early_release();
        step_t st[$];
        logic [15:0] e, o;
        st.push_back(s(8'h00, 1, 0, 0, 0));
        st.push_back(s(8'h04, 0, 1, 3'd2, 0));
        st.push_back(s(8'h48, 0, 1, 3'd3, 0));
        st.push_back(s(8'h48, 0, 1, 3'd3, 1));
        st.push_back(s(8'h40, 0, 1, 3'd6, 0));
        st.push_back(s(8'h40, 0, 1, 3'd6, 1));
        st.push_back(s(8'h00, 0, 0, 3'd6, 0));
        foreach (st[k]) begin
            req = st[k].rq; rst = st[k].rs; sb.push_back(st[k].ex);
            @(posedge clk); #1;
            e = sb.pop_front(); o = {gnt_valid, gnt_idx, gnt, hold_cnt};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL early_release step %0d: observed %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_idle_ptr();
        step_t st[$];
        logic [15:0] e, o;
        st.push_back(s(8'h00, 1, 0, 0, 0));
        st.push_back(s(8'h20, 0, 1, 3'd5, 0));
        st.push_back(s(8'h00, 0, 0, 3'd5, 0));
        st.push_back(s(8'h00, 0, 0, 3'd5, 0));
        st.push_back(s(8'h21, 0, 1, 3'd0, 0));
        st.push_back(s(8'h21, 0, 1, 3'd0, 1));
        foreach (st[k]) begin
            req = st[k].rq; rst = st[k].rs; sb.push_back(st[k].ex);
            @(posedge clk); #1;
            e = sb.pop_front(); o = {gnt_valid, gnt_idx, gnt, hold_cnt};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL idle_ptr step %0d: observed %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_lease();
        step_t st[$];
        logic [15:0] e, o;
        st.push_back(s(8'h00, 1, 0, 0, 0));
        st.push_back(s(8'h10, 0, 1, 3'd4, 0));
        st.push_back(s(8'hFF, 0, 1, 3'd4, 1));
        st.push_back(s(8'hFF, 0, 1, 3'd4, 2));
        st.push_back(s(8'hFF, 1, 0, 3'd0, 0));
        st.push_back(s(8'hFF, 0, 1, 3'd0, 0));
        st.push_back(s(8'hFF, 0, 1, 3'd0, 1));
        foreach (st[k]) begin
            req = st[k].rq; rst = st[k].rs; sb.push_back(st[k].ex);
            @(posedge clk); #1;
            e = sb.pop_front(); o = {gnt_valid, gnt_idx, gnt, hold_cnt};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid_lease step %0d: observed %h expected %h", k, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_early_release();
        test_idle_ptr();
        test_reset_mid_lease();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
